// File: rtl/filter_peak_detector.sv
// Peak detector for one filter output stream: finds threshold-crossing pulses,
// reports peak amplitude, peak timestamp, width and pile-up per pulse, then applies dead time.
module filter_peak_detector #(
    parameter int SIZE_FILTER_DATA = 16,
    parameter int DATA_WIDTH       = SIZE_FILTER_DATA,
    parameter int TIME_WIDTH       = 16,
    parameter int MAX_WIDTH        = 64,
    parameter int HOLDOFF_WIDTH    = 8,
    parameter int CNT_WIDTH        = 16,
    localparam int WW              = $clog2(MAX_WIDTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    input_data,
    input  logic [DATA_WIDTH-1:0]    threshold,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff,
    output logic                     peak_valid,
    output logic [DATA_WIDTH-1:0]    peak_amp,
    output logic [TIME_WIDTH-1:0]    peak_time,
    output logic [WW-1:0]            peak_width,
    output logic                     peak_pileup,
    output logic [CNT_WIDTH-1:0]     event_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARMED    = 2'd1,
        S_WAIT_LOW = 2'd2,
        S_HOLDOFF  = 2'd3
    } state_t;

    localparam logic [WW-1:0]            W_ONE    = WW'(1'b1);
    localparam logic [WW-1:0]            W_MAX    = WW'(MAX_WIDTH);
    localparam logic [TIME_WIDTH-1:0]    T_ONE    = TIME_WIDTH'(1'b1);
    localparam logic [CNT_WIDTH-1:0]     C_ONE    = CNT_WIDTH'(1'b1);
    localparam logic [HOLDOFF_WIDTH-1:0] H_ONE    = HOLDOFF_WIDTH'(1'b1);
    localparam logic [HOLDOFF_WIDTH-1:0] H_ZERO   = HOLDOFF_WIDTH'(1'b0);

    state_t                   r_state;
    logic [TIME_WIDTH-1:0]    r_time_cnt;
    logic [DATA_WIDTH-1:0]    r_d;
    logic [TIME_WIDTH-1:0]    r_t;
    logic [DATA_WIDTH-1:0]    r_thr;
    logic [DATA_WIDTH-1:0]    r_peak;
    logic [TIME_WIDTH-1:0]    r_ptime;
    logic [WW-1:0]            r_width;
    logic [HOLDOFF_WIDTH-1:0] r_hold;
    logic                     r_valid;
    logic [DATA_WIDTH-1:0]    r_amp_o;
    logic [TIME_WIDTH-1:0]    r_time_o;
    logic [WW-1:0]            r_width_o;
    logic                     r_pileup_o;
    logic [CNT_WIDTH-1:0]     r_count;

    logic w_above;
    logic w_above_peak;
    logic w_at_max;

    assign w_above      = (r_d > r_thr);
    assign w_above_peak = (r_d > r_peak);
    assign w_at_max     = (r_width == W_MAX);

    // Free-running timestamp and the sample/tag input register pair
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_time_cnt <= '0;
            r_d        <= '0;
            r_t        <= '0;
        end else begin
            r_time_cnt <= r_time_cnt + T_ONE;
            r_d        <= input_data;
            r_t        <= r_time_cnt;
        end
    end

    // Pulse FSM with registered result record and event counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_thr      <= '0;
            r_peak     <= '0;
            r_ptime    <= '0;
            r_width    <= '0;
            r_hold     <= '0;
            r_valid    <= 1'b0;
            r_amp_o    <= '0;
            r_time_o   <= '0;
            r_width_o  <= '0;
            r_pileup_o <= 1'b0;
            r_count    <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_thr <= threshold;
                    if (w_above) begin
                        r_peak  <= r_d;
                        r_ptime <= r_t;
                        r_width <= W_ONE;
                        r_state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (w_above && w_at_max) begin
                        r_valid    <= 1'b1;
                        r_amp_o    <= r_peak;
                        r_time_o   <= r_ptime;
                        r_width_o  <= r_width;
                        r_pileup_o <= 1'b1;
                        r_count    <= r_count + C_ONE;
                        r_state    <= S_WAIT_LOW;
                    end else if (w_above) begin
                        r_width <= r_width + W_ONE;
                        if (w_above_peak) begin
                            r_peak  <= r_d;
                            r_ptime <= r_t;
                        end
                    end else begin
                        r_valid    <= 1'b1;
                        r_amp_o    <= r_peak;
                        r_time_o   <= r_ptime;
                        r_width_o  <= r_width;
                        r_pileup_o <= 1'b0;
                        r_count    <= r_count + C_ONE;
                        r_hold     <= holdoff;
                        r_state    <= (holdoff == H_ZERO) ? S_IDLE : S_HOLDOFF;
                    end
                end
                S_WAIT_LOW: begin
                    // Truncated pulse already reported; only wait for it to fall
                    if (!w_above) begin
                        r_hold  <= holdoff;
                        r_state <= (holdoff == H_ZERO) ? S_IDLE : S_HOLDOFF;
                    end
                end
                S_HOLDOFF: begin
                    if (r_hold == H_ONE) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_hold <= r_hold - H_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign peak_valid  = r_valid;
    assign peak_amp    = r_amp_o;
    assign peak_time   = r_time_o;
    assign peak_width  = r_width_o;
    assign peak_pileup = r_pileup_o;
    assign event_count = r_count;

endmodule

// File: tb/tb_filter_peak_detector.sv
// Directed bench for filter_peak_detector: a default instance plus a narrow
// TIME_WIDTH=4 / CNT_WIDTH=2 instance for timestamp and counter wrap.
module tb_filter_peak_detector;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reset_b = 1'b0;
    logic [15:0] input_data = 16'd0;
    logic [15:0] threshold = 16'd100;
    logic [7:0]  holdoff = 8'd0;

    logic        peak_valid;
    logic [15:0] peak_amp;
    logic [15:0] peak_time;
    logic [6:0]  peak_width;
    logic        peak_pileup;
    logic [15:0] event_count;

    logic        peak_valid_b;
    logic [15:0] peak_amp_b;
    logic [3:0]  peak_time_b;
    logic [6:0]  peak_width_b;
    logic        peak_pileup_b;
    logic [1:0]  event_count_b;

    int n_cmp = 0;
    int n_fail = 0;
    int n_str_a = 0;
    int n_str_b = 0;
    int s0;

    filter_peak_detector dut (
        .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
        .holdoff(holdoff), .peak_valid(peak_valid), .peak_amp(peak_amp),
        .peak_time(peak_time), .peak_width(peak_width), .peak_pileup(peak_pileup),
        .event_count(event_count)
    );

    filter_peak_detector #(.TIME_WIDTH(4), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .reset(reset_b), .input_data(input_data), .threshold(threshold),
        .holdoff(holdoff), .peak_valid(peak_valid_b), .peak_amp(peak_amp_b),
        .peak_time(peak_time_b), .peak_width(peak_width_b), .peak_pileup(peak_pileup_b),
        .event_count(event_count_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one sample for one clock; observe strobes on the falling edge.
    task automatic drive(input logic [15:0] v);
        input_data = v;
        @(negedge clk);
        if (peak_valid === 1'b1) n_str_a++;
        if (peak_valid_b === 1'b1) n_str_b++;
    endtask

    task automatic chk_rec(input string tag, input logic [15:0] amp, input logic [15:0] tm,
                           input logic [6:0] w, input logic pu, input logic [15:0] cnt);
        chk({tag, "_valid"}, 32'(peak_valid), 32'd1);
        chk({tag, "_amp"}, 32'(peak_amp), 32'(amp));
        chk({tag, "_time"}, 32'(peak_time), 32'(tm));
        chk({tag, "_width"}, 32'(peak_width), 32'(w));
        chk({tag, "_pileup"}, 32'(peak_pileup), 32'(pu));
        chk({tag, "_count"}, 32'(event_count), 32'(cnt));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(peak_valid), 32'd0);
        chk("rst_amp", 32'(peak_amp), 32'd0);
        chk("rst_count", 32'(event_count), 32'd0);
        chk("rst_count_b", 32'(event_count_b), 32'd0);

        // Basic pulse: tags 0..9 idle, then 0,50,150,300,250,90,0 at tags 10..16
        reset = 1'b1;
        repeat (10) drive(16'd0);
        drive(16'd0); drive(16'd50); drive(16'd150); drive(16'd300); drive(16'd250);
        drive(16'd90);
        chk("basic_early", 32'(peak_valid), 32'd0);
        drive(16'd0);
        chk_rec("basic", 16'd300, 16'd13, 7'd3, 1'b0, 16'd1);
        drive(16'd0);
        chk("basic_one_cycle", 32'(peak_valid), 32'd0);
        chk("basic_hold_amp", 32'(peak_amp), 32'd300);

        // Tie: 150,200,200,50 at tags 20..23, first maximum kept
        drive(16'd0); drive(16'd0);
        drive(16'd150); drive(16'd200); drive(16'd200); drive(16'd50);
        drive(16'd0);
        chk_rec("tie", 16'd200, 16'd21, 7'd3, 1'b0, 16'd2);

        // Pile-up: 100 samples of 500 from tag 25, truncation at 64
        holdoff = 8'd3;
        s0 = n_str_a;
        for (int i = 1; i <= 100; i++) begin
            drive(16'd500);
            if (i == 65) chk("pile_early", 32'(peak_valid), 32'd0);
            if (i == 66) chk_rec("pile", 16'd500, 16'd25, 7'd64, 1'b1, 16'd3);
        end
        chk("pile_single", 32'(n_str_a - s0), 32'd1);
        repeat (6) drive(16'd0);
        chk("pile_no_second", 32'(n_str_a - s0), 32'd1);
        drive(16'd200); drive(16'd300); drive(16'd0);
        chk("after_pile_early", 32'(peak_valid), 32'd0);
        drive(16'd0);
        chk_rec("after_pile", 16'd300, 16'd132, 7'd2, 1'b0, 16'd4);

        // Holdoff=4: pulse on samples 2..4 after the emit ignored, one on sample 6 kept
        holdoff = 8'd4;
        repeat (5) drive(16'd0);
        drive(16'd200); drive(16'd0); drive(16'd0);
        chk_rec("hold_first", 16'd200, 16'd140, 7'd1, 1'b0, 16'd5);
        s0 = n_str_a;
        drive(16'd250); drive(16'd250); drive(16'd250); drive(16'd0);
        drive(16'd250); drive(16'd0); drive(16'd0);
        chk_rec("hold_second", 16'd250, 16'd147, 7'd1, 1'b0, 16'd6);
        chk("hold_strobes", 32'(n_str_a - s0), 32'd1);

        // Asynchronous reset in the middle of an armed pulse
        holdoff = 8'd0;
        repeat (5) drive(16'd0);
        drive(16'd300); drive(16'd300);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(peak_valid), 32'd0);
        chk("arst_amp", 32'(peak_amp), 32'd0);
        chk("arst_time", 32'(peak_time), 32'd0);
        chk("arst_width", 32'(peak_width), 32'd0);
        chk("arst_count", 32'(event_count), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        s0 = n_str_a;
        drive(16'd500); drive(16'd0);
        chk("arst_no_stale", 32'(n_str_a - s0), 32'd0);
        drive(16'd0);
        chk_rec("arst_next", 16'd500, 16'd0, 7'd1, 1'b0, 16'd1);

        // Threshold boundaries: equal, all-ones, zero
        s0 = n_str_a;
        drive(16'd100); drive(16'd100); repeat (3) drive(16'd0);
        chk("thr_equal", 32'(n_str_a - s0), 32'd0);
        threshold = 16'hFFFF;
        drive(16'd0); repeat (3) drive(16'hFFFF); repeat (2) drive(16'd0);
        chk("thr_ones", 32'(n_str_a - s0), 32'd0);
        threshold = 16'd0;
        repeat (4) drive(16'd0);
        chk("thr_zero", 32'(n_str_a - s0), 32'd0);
        drive(16'd1); drive(16'd0); drive(16'd0);
        chk("thr_zero_one", 32'(n_str_a - s0), 32'd1);
        chk("thr_zero_amp", 32'(peak_amp), 32'd1);
        threshold = 16'd100;
        repeat (2) drive(16'd0);

        // Wrap: 4-bit timestamps 15 then 2, 2-bit event counter 3 -> 0
        reset_b = 1'b1;
        repeat (15) drive(16'd0);
        drive(16'd400); drive(16'd0); drive(16'd0);
        chk("wrap_t15_valid", 32'(peak_valid_b), 32'd1);
        chk("wrap_t15_time", 32'(peak_time_b), 32'd15);
        chk("wrap_t15_amp", 32'(peak_amp_b), 32'd400);
        chk("wrap_cnt1", 32'(event_count_b), 32'd1);
        drive(16'd400); drive(16'd0); drive(16'd0);
        chk("wrap_t2_valid", 32'(peak_valid_b), 32'd1);
        chk("wrap_t2_time", 32'(peak_time_b), 32'd2);
        chk("wrap_cnt2", 32'(event_count_b), 32'd2);
        drive(16'd400); drive(16'd0); drive(16'd0);
        chk("wrap_cnt3", 32'(event_count_b), 32'd3);
        drive(16'd400); drive(16'd0); drive(16'd0);
        chk("wrap_cnt0_valid", 32'(peak_valid_b), 32'd1);
        chk("wrap_cnt0", 32'(event_count_b), 32'd0);
        chk("wrap_strobes", 32'(n_str_b), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/filter_peak_detector.md
Name: filter_peak_detector

Overview:
- Downstream consumer of one filter output (v1..v6 style, SIZE_FILTER_DATA wide).
- Detects threshold-crossing pulses and tracks the maximum sample over each pulse.
- Emits one result record per pulse: amplitude, timestamp of the peak, pulse width and a pile-up flag.
- Applies a programmable dead time after each record and keeps a running event counter.

Parameters:
DATA_WIDTH, SIZE_FILTER_DATA, width of filter samples (unsigned)
TIME_WIDTH, 16, width of free-running timestamp counter
MAX_WIDTH, 64, maximum pulse length in samples before forced emit
HOLDOFF_WIDTH, 8, width of dead-time setting
CNT_WIDTH, 16, width of event counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
input_data  in  DATA_WIDTH  filter output sample, one per clk
threshold  in  DATA_WIDTH  trigger level, unsigned
holdoff  in  HOLDOFF_WIDTH  dead time in clk cycles after each emit
peak_valid  out  1  one-cycle strobe qualifying the peak_* outputs
peak_amp  out  DATA_WIDTH  maximum sample of the pulse
peak_time  out  TIME_WIDTH  timestamp tag of the peak sample
peak_width  out  $clog2(MAX_WIDTH+1)  number of samples above threshold
peak_pileup  out  1  pulse truncated at MAX_WIDTH
event_count  out  CNT_WIDTH  total emitted records, wraps

Behaviour:
Reset:
- Asserting reset (reset=0) at any time, including mid-pulse, immediately clears every output to 0.
- Reset also clears time_cnt, all internal registers and the FSM (to IDLE).
- A pulse in progress at reset is discarded and produces no record.

Timestamp and input stage:
- time_cnt increments every clk and wraps modulo 2^TIME_WIDTH.
- Input stage: on each edge, input_data goes to d_r and time_cnt to t_r. This is the sample tag.
- The FSM evaluates d_r/t_r on the following edge.

FSM states:
- IDLE: if d_r > thr_l (strictly), go to ARMED.
  - On entry: latch thr_l <= threshold, peak <= d_r, ptime <= t_r, width <= 1.
  - While in IDLE, thr_l tracks threshold every cycle. Threshold is therefore frozen for the duration of a pulse.
- ARMED, d_r > thr_l:
  - width <= width+1.
  - If d_r > peak (strictly), update peak and ptime. On equal samples the first one is kept.
  - If width+1 would exceed MAX_WIDTH, emit with pileup=1 instead and go to WAIT_LOW.
- ARMED, d_r <= thr_l: emit with pileup=0 and go to HOLDOFF, or straight to IDLE if holdoff==0.
- WAIT_LOW:
  - Ignore samples while d_r > thr_l.
  - On d_r <= thr_l, go to HOLDOFF, or to IDLE if holdoff==0.
  - No second record is produced for the truncated pulse.
- HOLDOFF:
  - On entry, load the down-counter with holdoff. Decrement each clk.
  - Return to IDLE on the edge where the counter equals 1.
  - All samples are ignored in this state. A sample above threshold evaluated in the first IDLE cycle starts a new pulse.

Emit:
- On the emit edge, register peak_amp, peak_time, peak_width and peak_pileup, and pulse peak_valid high for exactly one cycle.
- event_count increments on the same edge.
- peak_* hold their values until the next emit. peak_valid is 0 otherwise.

Latency:
- Let sample k be the first at or below threshold, i.e. the one presented before edge k.
- peak_valid is high in the cycle following edge k+1.
- For a MAX_WIDTH truncation, the same latency applies, counted from the sample that would be number MAX_WIDTH+1.

Arithmetic:
- All comparisons are unsigned.
- width never exceeds MAX_WIDTH.
- An input of 0 with threshold of 0 never triggers.
- threshold = all-ones never triggers.

Test Plan:
1. Basic pulse: threshold=100, holdoff=0, samples 0,50,150,300,250,90,0 with tags 10..16 -> single peak_valid. Required values: peak_amp=300, peak_time=13, peak_width=3, peak_pileup=0, event_count=1. Strobe arrives 2 cycles after the sample 90.
2. Tie: samples 150,200,200,50 with tags 20..23 -> peak_amp=200, peak_time=21 (first max), width=3.
3. Pile-up: constant 500 for 100 samples, MAX_WIDTH=64 -> one record with width=64, pileup=1. Then no further record until the input drops to ≤100 and the holdoff expires. A subsequent pulse produces a normal record.
4. Holdoff: holdoff=4; a second pulse starting on the 2nd sample after the first emit is ignored entirely. The same pulse starting on the 6th sample after the first emit is recorded; event_count goes 1 -> 2.
5. Reset mid-pulse: drive reset=0 asynchronously (mid-cycle) during ARMED. All outputs read 0 immediately; no peak_valid after release. time_cnt restarts from 0 and the next pulse is tagged from 0.
6. Wrap: TIME_WIDTH=4 with a peak at time_cnt 15, and the next peak 3 cycles later -> peak_time values 15 then 2. Separately preset event_count to all-ones, emit once -> it wraps to 0.
